// File: rtl/micro_sequencer.sv
// Microsequencer: owns uPC/uIR, drives sequential and speculative ROM ports.
// Optional MICROSEQ_STACK_CHECK_EN: stack over/underflow halts with sticky err_out.
module micro_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic [7:0]        cond_in,
    input  logic              op_valid_in,
    input  logic [ADDR_W-1:0] dispatch_addr_in,
    output logic              op_ready_out,
    output logic [ADDR_W-1:0] micro_code_addr_out,
    input  logic [DATA_W-1:0] micro_code_data_in,
    output logic [ADDR_W-1:0] micro_code_addr_speculative_fetch_out,
    input  logic [DATA_W-1:0] micro_code_data_speculative_fetch_in,
    output logic [15:0]       ctrl_out,
    output logic              ctrl_valid_out,
    output logic [ADDR_W-1:0] upc_out,
    output logic              err_out
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JUMP = 3'b001;
    localparam logic [2:0] OP_BRIF = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_DISP = 3'b101;
    localparam logic [2:0] OP_WAIT = 3'b110;
    localparam logic [2:0] OP_END  = 3'b111;

    localparam int PW = $clog2(STACK_DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] upc;
    logic [DATA_W-1:0] uir;
    logic              err_q;

    // Extra pointer bit distinguishes full from empty
    logic [PW:0]       sp;
    logic [PW:0]       sp_m1;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic [2:0]        seq_op;
    logic [2:0]        cond_sel;
    logic [ADDR_W-1:0] target;
    logic              cond;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic [ADDR_W-1:0] spec_addr;
    logic              taken;
    logic              hold;
    logic              push;
    logic              pop;
    logic              stack_err;
    logic              run;
    logic              step;
    logic              unused_bits;

    assign seq_op      = uir[31:29];
    assign cond_sel    = uir[28:26];
    assign target      = uir[16 +: ADDR_W];
    assign unused_bits = ^uir[25:24];
    assign cond        = cond_in[cond_sel];
    assign upc_inc     = upc + 1'b1;
    assign sp_m1       = sp - 1'b1;
    assign stack_top   = stack[sp_m1[PW-1:0]];
    assign run         = (state == ST_RUN);

    always_comb begin
        spec_addr = upc;
        taken     = 1'b0;
        hold      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (seq_op)
            OP_JUMP: begin
                spec_addr = target;
                taken     = 1'b1;
            end
            OP_BRIF: begin
                spec_addr = target;
                taken     = cond;
            end
            OP_CALL: begin
                spec_addr = target;
                taken     = 1'b1;
                push      = 1'b1;
            end
            OP_RET: begin
                spec_addr = stack_top;
                taken     = 1'b1;
                pop       = 1'b1;
            end
            OP_DISP: begin
                spec_addr = dispatch_addr_in;
                taken     = op_valid_in;
                hold      = !op_valid_in;
            end
            OP_WAIT: hold = !cond;
            OP_END: begin
                spec_addr = RESET_ADDR;
                taken     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MICROSEQ_STACK_CHECK_EN
    assign stack_err = (push && sp == (PW+1)'(STACK_DEPTH))
                     || (pop && sp == '0);
`else
    assign stack_err = 1'b0;
`endif

    assign step = run && !stall_in && !hold;

    always_comb begin
        micro_code_addr_out                   = upc_inc;
        micro_code_addr_speculative_fetch_out = upc;
        if (state == ST_BOOT) begin
            micro_code_addr_out                   = RESET_ADDR;
            micro_code_addr_speculative_fetch_out = RESET_ADDR;
        end else if (run) begin
            micro_code_addr_speculative_fetch_out = spec_addr;
        end
    end

    assign op_ready_out   = run && seq_op == OP_DISP
                          && op_valid_in && !stall_in;
    assign ctrl_valid_out = step;
    assign ctrl_out       = ctrl_valid_out ? uir[15:0] : 16'h0000;
    assign upc_out        = upc;
    assign err_out        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
            upc   <= RESET_ADDR;
            uir   <= '0;
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    uir   <= micro_code_data_in;
                    upc   <= RESET_ADDR;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (step) begin
                        if (stack_err) begin
                            state <= ST_HALT;
                            err_q <= 1'b1;
                        end else begin
                            if (taken) begin
                                uir <= micro_code_data_speculative_fetch_in;
                                upc <= spec_addr;
                            end else begin
                                uir <= micro_code_data_in;
                                upc <= upc_inc;
                            end
                            if (push)
                                sp <= sp + 1'b1;
                            else if (pop)
                                sp <= sp_m1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Return-address storage needs no reset; sp defines validity
    always_ff @(posedge clk) begin
        if (step && push && !stack_err)
            stack[sp[PW-1:0]] <= upc_inc;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microsequencer stage directly upstream of the 256x32 micro-instruction ROM. Owns the micro-PC (uPC) and the current micro-instruction register (uIR).
- Every cycle it drives two ROM read addresses:
  - normal port: sequential address uPC+1
  - speculative port: the non-sequential candidate (jump/branch target, return address, or dispatch address)
- At the clock edge it loads one of the two returned words into uIR. Taken branches therefore cost zero bubbles.
- Drives the 16-bit control field to the datapath.

Parameters:
- ADDR_W, 8, micro-address width (ROM depth 2^ADDR_W)
- DATA_W, 32, micro-instruction width
- STACK_DEPTH, 4, micro-return stack entries (power of 2, 2..16)
- RESET_ADDR, 0, first micro-address fetched after reset; END also returns here

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  datapath stall; freezes all sequencer state
- cond_in  in  8  condition flags, selected by uIR cond_sel
- op_valid_in  in  1  decoder presents a macro-op dispatch address
- dispatch_addr_in  in  ADDR_W  micro-entry address for the current macro-op
- op_ready_out  out  1  dispatch accepted this cycle
- micro_code_addr_out  out  ADDR_W  to ROM normal port (sequential)
- micro_code_data_in  in  DATA_W  ROM normal-port word
- micro_code_addr_speculative_fetch_out  out  ADDR_W  to ROM speculative port
- micro_code_data_speculative_fetch_in  in  DATA_W  ROM speculative-port word
- ctrl_out  out  16  uIR[15:0]; forced to 0 when ctrl_valid_out=0
- ctrl_valid_out  out  1  ctrl_out is live this cycle
- upc_out  out  ADDR_W  current uPC (debug)
- err_out  out  1  sticky stack error (feature-dependent)

Behaviour:
Micro-instruction fields:
- [31:29] seq_op: 000 NEXT, 001 JUMP, 010 BRIF, 011 CALL, 100 RET, 101 DISPATCH, 110 WAIT, 111 END
- [28:26] cond_sel; cond = cond_in[cond_sel]
- [23:16] target; bits [25:24] are reserved and ignored
- [15:0] ctrl

States:
- BOOT: normal port driven with RESET_ADDR. Next edge: uIR<=micro_code_data_in, uPC<=RESET_ADDR, go to RUN.
- RUN: normal operation, see below.
- HALT: reachable only with the optional feature. Holds until reset.

Reset (async, rst_n=0):
- state=BOOT, uPC=RESET_ADDR, uIR=0, stack pointer=0, err_out=0, op_ready_out=0, ctrl_valid_out=0.

RUN, combinational outputs:
- micro_code_addr_out = uPC+1, modulo 2^ADDR_W (255 wraps to 0).
- Speculative address by seq_op:
  - JUMP/BRIF/CALL: target
  - RET: stack top
  - DISPATCH: dispatch_addr_in
  - END: RESET_ADDR
  - otherwise: uPC

RUN, taken decision:
- Always taken: JUMP, CALL, RET, END.
- BRIF: taken if cond=1.
- DISPATCH: taken if op_valid_in=1.
- WAIT: if cond=0, hold uPC and uIR.

RUN, edge update when stall_in=0:
- Taken: uIR<=speculative word, uPC<=speculative address.
- Not taken (non-WAIT): uIR<=normal word, uPC<=uPC+1.
- DISPATCH with op_valid_in=0: hold, same as WAIT.
- op_ready_out = (state RUN) & (seq_op DISPATCH) & op_valid_in & !stall_in. It is combinational and high for exactly the accepting cycle.

Stack:
- CALL pushes uPC+1 (sequential return point).
- RET pops.
- Full stack on CALL, or empty stack on RET, is handled per the optional feature.

ctrl_valid_out:
- =1 in RUN.
- =0 in BOOT, HALT, while stall_in=1, and in hold cycles of WAIT or DISPATCH.

stall_in=1:
- No register changes and ROM addresses held.
- Does not block BOOT completion: BOOT ignores stall_in.

Optional Feature:
- Macro: MICROSEQ_STACK_CHECK_EN
- Defined:
  - CALL with stack full, or RET with stack empty, sets err_out=1 (sticky) and enters HALT.
  - No push/pop occurs; ctrl_valid_out=0 thereafter.
- Undefined:
  - Stack pointer wraps modulo STACK_DEPTH and the oldest entry is overwritten.
  - RET on empty stack returns the wrapped entry.
  - err_out tied 0; HALT unreachable.

Test Plan:
- Reset, with ROM[0]=NEXT ctrl 0x0011 and ROM[1]=NEXT ctrl 0x0022 -> BOOT cycle shows ctrl_valid_out=0; then ctrl_out 0x0011, then 0x0022; upc_out 0 then 1.
- ROM[1]=BRIF cond_sel=2 target 0x40, cond_in=0x04 -> next uPC=0x40 with no bubble. Repeat with cond_in=0x00 -> uPC=2.
- CALL 0x80 at uPC 5, then RET at 0x80 -> uPC sequence 5, 0x80, 6. Stack pointer returns to 0.
- DISPATCH with op_valid_in=0 for 3 cycles, then 1 with dispatch_addr_in=0x90 -> uPC held, ctrl_valid_out=0 for the 3 cycles; op_ready_out high for one cycle; uPC=0x90.
- stall_in=1 for 4 cycles mid-sequence -> uPC, uIR and ROM addresses frozen; resumes at identical point. rst_n pulsed low mid-run -> immediate BOOT, uPC=RESET_ADDR.
- Five nested CALLs with STACK_DEPTH=4 -> with MICROSEQ_STACK_CHECK_EN: err_out=1, HALT, ctrl_valid_out=0. Without it: wrap, err_out=0.
